// File: rtl/mem_responder.sv
// mem_responder
//
// Word-organized single-port scratch memory that answers the core's mem_*
// request/response bus. One read or one byte-masked write is taken at a
// time, held for LATENCY cycles, and completed with a one-cycle mem_resp
// pulse.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (word-aligned)
//   LATENCY      cycles from request sample to mem_resp (1..15)
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   mem_addr   byte address, bits [1:0] ignored
//   mem_rmask  read byte enables, nonzero = read request
//   mem_wmask  write byte enables, nonzero = write request
//   mem_wdata  write data, lane i = bits 8i+7:8i
//   mem_rdata  full read word, valid in the mem_resp cycle of a read
//   mem_resp   one-cycle completion pulse
//   err        sticky error (out of range or read+write together)
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1eceb000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [3:0]  rmask_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      curAddr;
    logic [3:0]       curRmask;
    logic [3:0]       curWmask;
    logic [31:0]      offset;
    logic             inRange;
    logic             badAccess;
    logic [IDX_W-1:0] idx;
    logic             request;
    logic             enterResp;
    logic             writeEn;

    // Decode the transaction being worked on. In IDLE the latches are not
    // loaded yet, so with LATENCY=1 the read into RESP must decode straight
    // from the bus; in every other state the latched copy is used.
    // BASE_ADDR is word-aligned, so the low address bits fall into offset[1:0]
    // and affect neither the range test (SPAN is a multiple of 4) nor idx.
    always_comb begin
        curAddr   = (state_q == IDLE) ? mem_addr  : addr_q;
        curRmask  = (state_q == IDLE) ? mem_rmask : rmask_q;
        curWmask  = (state_q == IDLE) ? mem_wmask : wmask_q;
        offset    = curAddr - BASE_ADDR;
        inRange   = offset < SPAN;
        idx       = offset[IDX_W+1:2];
        badAccess = !inRange || ((|curRmask) && (|curWmask));
        request   = (|mem_rmask) || (|mem_wmask);
    end

    // Next-state logic: IDLE waits for a request and loads the latency
    // counter, WAIT counts down until cnt reaches 1, RESP always returns
    // to IDLE so the pulse can never last two cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        enterResp = (state_d == RESP) && (state_q != RESP);
        writeEn   = (state_q == RESP) && (|wmask_q) && !badAccess;
    end

    // State, counter, request latches, read data and sticky error. The read
    // word and the error are both resolved on the edge that enters RESP so
    // they are stable for the whole response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            rmask_q <= 4'd0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && request) begin
                addr_q  <= mem_addr;
                rmask_q <= mem_rmask;
                wmask_q <= mem_wmask;
                wdata_q <= mem_wdata;
            end
            if (enterResp && (|curRmask)) begin
                rdata_q <= badAccess ? BAD_WORD : mem[idx];
            end
            if (enterResp && badAccess) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage array, deliberately not reset. The write lands in the RESP
    // cycle, and reset in that same cycle wins so the write is dropped.
    always_ff @(posedge clk) begin
        if (!rst && writeEn) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = (state_q == RESP);
    assign err       = err_q;

endmodule
